// File: rtl/math_pkg.sv
// Shared definitions for the sequential math blocks: FSM state encoding and
// the legal operand-width range.
package math_pkg;

    // State encoding shared by every multi-cycle math unit.
    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE   = 2'd0;
    localparam seq_state_t ST_CALC   = 2'd1;
    localparam seq_state_t ST_FINISH = 2'd2;

    // Supported operand widths for the sequential math units.
    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    // True when a WIDTH parameter is inside the supported range.
    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/math_div_step.sv
// One restoring-division step: compare the shifted partial remainder against
// the divisor and subtract when it fits.
module math_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   prem_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] prem_o,
    output logic             qbit_o
);

    // The partial remainder is one bit wider than the divisor so that an
    // unsigned divisor with its MSB set still compares correctly after the
    // shift. When the subtraction happens the difference is always below
    // the divisor, so WIDTH bits are enough to hold the result.
    always_comb begin
        qbit_o = (prem_i >= {1'b0, divisor_i});
        if (qbit_o) begin
            prem_o = WIDTH'(prem_i - {1'b0, divisor_i});
        end else begin
            prem_o = prem_i[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/math_divider_seq.sv
// Sequential restoring divider, one quotient bit per clock, with optional
// two's-complement mode that works on magnitudes and fixes signs at the end.
module math_divider_seq
    import math_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             error
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH - 1){1'b0}}};

    // Refuse to elaborate with a width the shared math blocks do not support.
    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("math_divider_seq: WIDTH out of supported range");
        end
    endgenerate

    seq_state_t        state_q, state_d;
    logic [CW-1:0]     stepCnt_q, stepCnt_d;
    logic [WIDTH-1:0]  remMag_q, remMag_d;
    logic [WIDTH-1:0]  quoShift_q, quoShift_d;
    logic [WIDTH-1:0]  divMag_q, divMag_d;
    logic              negQuo_q, negQuo_d;
    logic              negRem_q, negRem_d;
    logic              errPend_q, errPend_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  quotient_q, quotient_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;
    logic              error_q, error_d;

    logic              signedReq;
    logic              dividendNeg;
    logic              divisorNeg;
    logic [WIDTH-1:0]  dividendMag;
    logic [WIDTH-1:0]  divisorMag;
    logic              divByZero;
    logic              signedOverflow;

    logic [WIDTH:0]    shiftedRem;
    logic [WIDTH-1:0]  stepRem;
    logic              stepBit;

    // Decode the live operands so they can be captured in magnitude form on
    // the accepting edge. The most negative value still has a representable
    // magnitude as an unsigned WIDTH-bit number.
    always_comb begin
        signedReq      = SIGNED_EN && signed_mode;
        dividendNeg    = signedReq && dividend[WIDTH-1];
        divisorNeg     = signedReq && divisor[WIDTH-1];
        dividendMag    = dividendNeg ? -dividend : dividend;
        divisorMag     = divisorNeg  ? -divisor  : divisor;
        divByZero      = (divisor == '0);
        signedOverflow = signedReq && (dividend == MOST_NEG) && (divisor == '1);
    end

    // The next dividend bit enters the partial remainder from the top of the
    // shift register, which also collects quotient bits at its bottom.
    assign shiftedRem = {remMag_q, quoShift_q[WIDTH-1]};

    math_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .prem_i    (shiftedRem),
        .divisor_i (divMag_q),
        .prem_o    (stepRem),
        .qbit_o    (stepBit)
    );

    // Control and datapath next-state: capture in IDLE, iterate in CALC,
    // apply signs and publish results in FINISH.
    always_comb begin
        state_d     = state_q;
        stepCnt_d   = stepCnt_q;
        remMag_d    = remMag_q;
        quoShift_d  = quoShift_q;
        divMag_d    = divMag_q;
        negQuo_d    = negQuo_q;
        negRem_d    = negRem_q;
        errPend_d   = errPend_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        error_d     = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stepCnt_d  = '0;
                    remMag_d   = '0;
                    quoShift_d = dividendMag;
                    divMag_d   = divisorMag;
                    negQuo_d   = dividendNeg ^ divisorNeg;
                    negRem_d   = dividendNeg;
                    errPend_d  = divByZero || signedOverflow;
                    state_d    = (divByZero || signedOverflow) ? ST_FINISH : ST_CALC;
                end
            end

            ST_CALC: begin
                remMag_d   = stepRem;
                quoShift_d = {quoShift_q[WIDTH-2:0], stepBit};
                stepCnt_d  = stepCnt_q + 1'b1;
                if (stepCnt_q == LAST_STEP) begin
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (errPend_q) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    error_d     = 1'b1;
                end else begin
                    quotient_d  = negQuo_q ? -quoShift_q : quoShift_q;
                    remainder_d = negRem_q ? -remMag_q   : remMag_q;
                    error_d     = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register everything; reset aborts any operation in flight and clears
    // the published results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stepCnt_q   <= '0;
            remMag_q    <= '0;
            quoShift_q  <= '0;
            divMag_q    <= '0;
            negQuo_q    <= 1'b0;
            negRem_q    <= 1'b0;
            errPend_q   <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stepCnt_q   <= stepCnt_d;
            remMag_q    <= remMag_d;
            quoShift_q  <= quoShift_d;
            divMag_q    <= divMag_d;
            negQuo_q    <= negQuo_d;
            negRem_q    <= negRem_d;
            errPend_q   <= errPend_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            error_q     <= error_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign error     = error_q;

endmodule

// File: doc/math_divider_seq.md
MATH_DIVIDER_SEQ -- requirements
Module: math_divider_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal 2..32).
REQ-002 Parameter: SIGNED_EN, 1, 1 = signed mode selectable via signed_mode; 0 = signed_mode ignored, unsigned only.
REQ-003 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: start  in  1  request; sampled only while idle.
REQ-006 Port: signed_mode  in  1  two's-complement operation when high (SIGNED_EN=1); captured with start.
REQ-007 Port: dividend  in  WIDTH  numerator; captured with start.
REQ-008 Port: divisor  in  WIDTH  denominator; captured with start.
REQ-009 Port: busy  out  1  high while an operation is in progress (state != IDLE).
REQ-010 Port: done  out  1  one-cycle pulse; results valid in that cycle.
REQ-011 Port: quotient  out  WIDTH  registered quotient.
REQ-012 Port: remainder  out  WIDTH  registered remainder.
REQ-013 Port: error  out  1  registered; divide-by-zero or signed overflow.

Function
REQ-014 States SHALL be IDLE, CALC, FINISH; IDLE->CALC on accepted start with valid operands; CALC->FINISH after WIDTH iterations; FINISH->IDLE unconditionally.
REQ-015 Start SHALL be accepted only in IDLE; start while busy SHALL be ignored with no effect on the running operation.
REQ-016 Operands and mode SHALL be captured on the accepting edge (edge 0); later input changes SHALL have no effect.
REQ-017 CALC SHALL perform one restoring step per cycle: shift {partial remainder, dividend} left 1, subtract divisor if partial remainder >= divisor, set quotient bit, MSB first.
REQ-018 Normal latency: results registered and done=1 after edge WIDTH+1; done low after edge WIDTH+2.
REQ-019 Signed mode SHALL divide magnitudes, negate quotient if operand signs differ, give remainder the dividend's sign (truncating division); negation occurs in FINISH.
REQ-020 Divisor=0 SHALL skip CALC (IDLE->FINISH), giving quotient=0, remainder=0, error=1, done after edge 1.
REQ-021 Signed mode with dividend = most-negative and divisor = all ones SHALL be treated as REQ-020 (error=1, q=0, r=0, latency 1).
REQ-022 error SHALL be 0 on every non-error completion.
REQ-023 quotient, remainder, error SHALL hold their values from the last done until the next done.
REQ-024 A start asserted in the done cycle (state IDLE) SHALL be accepted.
REQ-025 Internal partial remainder SHALL be WIDTH+1 bits to avoid compare overflow for unsigned operands with MSB set.

Reset
REQ-026 rst high at a rising edge SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, error=0.
REQ-027 rst during CALC or FINISH SHALL abort the operation; no done for it.
REQ-028 rst SHALL take priority over start on the same edge.

Structure
REQ-029 State encoding (IDLE, CALC, FINISH) and the WIDTH range check SHALL live in shared package math_pkg, reused by other sequential math blocks.
REQ-030 The restoring step SHALL be sub-module math_div_step (combinational, WIDTH-parametrised: partial remainder, divisor in; next remainder, quotient bit out).
REQ-031 Sign handling and the iteration counter ($clog2(WIDTH+1) bits) SHALL live in the top module.

Verification (WIDTH=8, SIGNED_EN=1)
REQ-032 Unsigned 200/7 -> quotient=28, remainder=4, error=0, done exactly 9 edges after start edge, busy high throughout.
REQ-033 Unsigned 100/0 -> quotient=0, remainder=0, error=1, done 1 edge after start, busy high for 1 cycle.
REQ-034 Signed 0x9C (-100) / 0x07 -> quotient=0xF2 (-14), remainder=0xFE (-2); signed 0x80 / 0xFF -> error=1, q=0, r=0.
REQ-035 Start 255/16, second start 10/2 at edge 3 -> ignored, result q=15, r=15; then start 10/2 in done cycle -> accepted, q=5, r=0.
REQ-036 Start 200/7, rst at edge 4 -> no done, all outputs 0 after reset; following 50/5 -> q=10, r=0 with normal latency.
